// File: rtl/baby_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | baby_bridge_pkg : shared types and constants for baby_mem_bridge         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package baby_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  localparam int   BYTES_PER_WORD = 4;
  localparam int   CMD_RW_BIT     = 7;
  localparam logic RW_READ        = 1'b0;
  localparam logic RW_WRITE       = 1'b1;

endpackage : baby_bridge_pkg
`default_nettype wire

// File: rtl/bridge_byte_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bridge_byte_lane : byte slot counter, write-byte mux, read shadow word   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bridge_byte_lane
  import baby_bridge_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              clear,
  input  logic              step,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BYTE_W-1:0] rbyte,
  output logic [BYTE_W-1:0] wbyte,
  output logic [WORD_W-1:0] word,
  output logic              last
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] shadow_q;

  // The current slot's incoming byte is merged in so the final ack yields a full word.
  always_comb begin
    word = shadow_q;
    word[cnt_q*BYTE_W +: BYTE_W] = rbyte;
  end

  assign wbyte = wdata[cnt_q*BYTE_W +: BYTE_W];
  assign last  = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else if (clear) begin
      cnt_q    <= '0;
    end else if (step) begin
      cnt_q    <= cnt_q + CNT_W'(1);
      shadow_q <= word;
    end
  end

endmodule : bridge_byte_lane
`default_nettype wire

// File: rtl/baby_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | baby_mem_bridge : 32-bit core RAM port to 8-bit store bus sequencer      |
// | Optional ack timeout enabled by defining BRIDGE_TIMEOUT_EN.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module baby_mem_bridge
  import baby_bridge_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int BYTE_W         = 8,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic [BYTE_W-1:0] ext_data_o,
  input  logic [BYTE_W-1:0] ext_data_i,
  output logic              ext_oe_o,
  output logic              ext_valid_o,
  input  logic              ext_ack_i,
  output logic              err_o
);

  bridge_state_t     state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              active;
  logic              xfer;
  logic              timeout;
  logic              lane_clear;
  logic              lane_step;
  logic              lane_last;
  logic [BYTE_W-1:0] lane_wbyte;
  logic [WORD_W-1:0] lane_word;
  logic [BYTE_W-1:0] cmd_byte;

  assign active = (state_q == CMD) || (state_q == DATA);
  assign xfer   = active && ext_ack_i;

  always_comb begin
    cmd_byte                 = '0;
    cmd_byte[ADDR_W-1:0]     = addr_q;
    cmd_byte[CMD_RW_BIT]     = rw_q;
  end

  // Outputs decode from registered state only, so they move solely on a clock edge.
  always_comb begin
    ext_valid_o = active;
    ext_oe_o    = (state_q == CMD) || ((state_q == DATA) && (rw_q == RW_WRITE));
    ext_data_o  = '0;
    case (state_q)
      CMD:     ext_data_o = cmd_byte;
      DATA:    ext_data_o = (rw_q == RW_WRITE) ? lane_wbyte : '0;
      default: ext_data_o = '0;
    endcase
  end

  assign ready_o = (state_q == DONE);
  assign busy_o  = active;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  assign timeout = active && !ext_ack_i && (wait_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_d = 8'd0;
    if (active && !ext_ack_i && !timeout) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    lane_clear = 1'b0;
    lane_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          rw_d    = rw_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          state_d = CMD;
        end
      end
      CMD: begin
        if (xfer) begin
          lane_clear = 1'b1;
          state_d    = DATA;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (rw_q == RW_READ) rdata_d = '0;
        end
      end
      DATA: begin
        if (xfer) begin
          lane_step = 1'b1;
          if (lane_last) begin
            state_d = DONE;
            if (rw_q == RW_READ) rdata_d = lane_word;
          end
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (rw_q == RW_READ) rdata_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  bridge_byte_lane #(
    .BYTE_W (BYTE_W),
    .WORD_W (WORD_W)
  ) u_lane (
    .clock   (clock),
    .reset_i (reset_i),
    .clear   (lane_clear),
    .step    (lane_step),
    .wdata   (wdata_q),
    .rbyte   (ext_data_i),
    .wbyte   (lane_wbyte),
    .word    (lane_word),
    .last    (lane_last)
  );

endmodule : baby_mem_bridge
`default_nettype wire
